// File: rtl/multdiv_pkg.sv
// Shared types and constants for the signed 32-bit multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  localparam int          MD_STEPS = 32;
  localparam int          MD_CNT_W = 6;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  // Magnitude of a two's-complement word; INT_MIN maps to 0x80000000 as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/multdiv_unit_addsub33.sv
// 33-bit adder/subtractor (a + b, or a - b when sub=1), carry-select structure.
// Latency: combinational.
// Backpressure: none.
module addsub33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] sum
);

  logic [32:0] b_eff;
  logic [16:0] lo_sum;
  logic [16:0] hi_sum0;
  logic [16:0] hi_sum1;

  // Low 16 bits ripple; upper 17 bits precomputed for both carries and selected.
  always_comb begin
    b_eff   = sub ? ~b : b;
    lo_sum  = {1'b0, a[15:0]} + {1'b0, b_eff[15:0]} + {16'd0, sub};
    hi_sum0 = a[32:16] + b_eff[32:16];
    hi_sum1 = a[32:16] + b_eff[32:16] + 17'd1;
    sum     = {(lo_sum[16] ? hi_sum1 : hi_sum0), lo_sum[15:0]};
  end

endmodule

// File: rtl/multdiv_unit.sv
// Signed 32-bit multiply (shift-add) / divide (restoring) unit for the execute stage.
// Latency: fixed 33 cycles from start edge to registered result; RDY is a one-cycle pulse.
// Backpressure: none; a new valid start aborts any operation in flight without RDY.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  md_state_t             state;
  md_state_t             state_nxt;
  logic [MD_CNT_W-1:0]   cnt;
  logic [63:0]           prod;       // product (MUL) or {remainder, dividend/quotient} (DIV)
  logic [63:0]           prod_nxt;
  logic [31:0]           opnd;       // multiplicand (MUL) or divisor magnitude (DIV)
  logic                  is_div;
  logic                  a_sgn;
  logic                  b_sgn;
  logic                  b_zero;

  logic                  start_mul;
  logic                  start_div;
  logic                  load;
  logic                  step;
  logic                  finish;
  logic                  last_step;

  logic [32:0]           add_a;
  logic [32:0]           add_b;
  logic                  add_sub;
  logic [32:0]           add_sum;

  logic [31:0]           quot;
  logic                  sgn_diff;
  logic [31:0]           res_nxt;
  logic                  exc_nxt;

  assign start_mul = ctrl_MULT & ~ctrl_DIV;
  assign start_div = ctrl_DIV & ~ctrl_MULT;
  assign last_step = (cnt == MD_CNT_W'(MD_STEPS - 1));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and control strobes; a valid start wins in every state.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    if (start_mul || start_div) begin
      load      = 1'b1;
      state_nxt = start_mul ? MUL : DIV;
    end else begin
      case (state)
        MUL, DIV: begin
          step = 1'b1;
          if (last_step) begin
            state_nxt = DONE;
          end
        end
        DONE: begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Adder operands: MUL adds/subtracts the multiplicand into the upper half,
  // DIV trial-subtracts the divisor from the left-shifted partial remainder.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    if (is_div) begin
      add_a   = {1'b0, prod[62:31]};
      add_b   = {1'b0, opnd};
      add_sub = 1'b1;
    end else begin
      add_a   = {prod[63], prod[63:32]};
      add_b   = prod[0] ? {opnd[31], opnd} : 33'd0;
      add_sub = last_step;    // multiplier sign bit carries negative weight
    end
  end

  addsub33 u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (add_sum)
  );

  // One iteration of the selected algorithm.
  always_comb begin
    prod_nxt = prod;
    if (is_div) begin
      prod_nxt = add_sum[32] ? {prod[62:0], 1'b0}
                             : {add_sum[31:0], prod[30:0], 1'b1};
    end else begin
      prod_nxt = {add_sum, prod[31:1]};
    end
  end

  // Final result and exception, applied on the DONE edge.
  always_comb begin
    quot     = prod[31:0];
    sgn_diff = a_sgn ^ b_sgn;
    res_nxt  = prod[31:0];
    exc_nxt  = 1'b0;
    if (is_div) begin
      if (b_zero) begin
        res_nxt = '0;
        exc_nxt = 1'b1;
      end else begin
        res_nxt = sgn_diff ? (~quot + 32'd1) : quot;
        // Same-sign quotient of 2^31 only arises from INT_MIN / -1.
        exc_nxt = !sgn_diff && (quot == INT_MIN);
      end
    end else begin
      exc_nxt = !((&prod[63:31]) || !(|prod[63:31]));
    end
  end

  // Datapath: operand capture, iteration, counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt            <= '0;
      prod           <= '0;
      opnd           <= '0;
      is_div         <= 1'b0;
      a_sgn          <= 1'b0;
      b_sgn          <= 1'b0;
      b_zero         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= finish;
      if (load) begin
        cnt    <= '0;
        is_div <= start_div;
        a_sgn  <= data_operandA[31];
        b_sgn  <= data_operandB[31];
        b_zero <= (data_operandB == '0);
        if (start_div) begin
          prod <= {32'd0, mag32(data_operandA)};
          opnd <= mag32(data_operandB);
        end else begin
          prod <= {32'd0, data_operandB};
          opnd <= data_operandA;
        end
      end else if (step) begin
        cnt  <= cnt + MD_CNT_W'(1);
        prod <= prod_nxt;
      end
      if (finish) begin
        data_result    <= res_nxt;
        data_exception <= exc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_vec = 0;
  int n_bad = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  // Drive a start for one edge (E0); returns 1ns after E0 with controls cleared.
  task automatic start_op(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // Count edges until RDY is seen (lat=-1 if budget expires); flags output changes before RDY.
  task automatic wait_rdy(input int budget, output int lat, output bit changed);
    logic [31:0] r0;
    logic        e0;
    r0      = data_result;
    e0      = data_exception;
    lat     = -1;
    changed = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1) begin
        lat = i;
        return;
      end
      if (data_result !== r0 || data_exception !== e0) changed = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_vec++;
    if (data_result !== 32'd0) begin
      n_bad++; $display("FAIL reset_result: got %h want %h", data_result, 32'd0);
    end
    n_vec++;
    if (data_exception !== 1'b0) begin
      n_bad++; $display("FAIL reset_exc: got %b want 0", data_exception);
    end
    n_vec++;
    if (data_resultRDY !== 1'b0) begin
      n_bad++; $display("FAIL reset_rdy: got %b want 0", data_resultRDY);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Run one op and check result, exception, latency and single-cycle RDY.
  task automatic check_op(input string name, input bit div, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ee);
    int lat;
    bit chg;
    start_op(!div, div, a, b);
    wait_rdy(60, lat, chg);
    n_vec++;
    if (lat !== 33) begin
      n_bad++; $display("FAIL %s_latency: got %0d want 33", name, lat);
    end
    n_vec++;
    if (data_result !== er) begin
      n_bad++; $display("FAIL %s_result: got %h want %h", name, data_result, er);
    end
    n_vec++;
    if (data_exception !== ee) begin
      n_bad++; $display("FAIL %s_exc: got %b want %b", name, data_exception, ee);
    end
    @(posedge clock);
    #1;
    n_vec++;
    if (data_resultRDY !== 1'b0) begin
      n_bad++; $display("FAIL %s_rdy_width: got %b want 0", name, data_resultRDY);
    end
  endtask

  task automatic test_mul;
    check_op("mul_7x-6",      1'b0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
    check_op("mul_2^16x2^16", 1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1);
    check_op("mul_-1x-1",     1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check_op("mul_min_x1",    1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0);
    check_op("mul_min_x-1",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    check_op("mul_x0",        1'b0, 32'd12345,      32'd0,         32'd0,         1'b0);
  endtask

  task automatic test_div;
    check_op("div_-100/7",    1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0);
    check_op("div_5/0",       1'b1, 32'd5,         32'd0,         32'd0,         1'b1);
    check_op("div_min/-1",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    check_op("div_100/-7",    1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
    check_op("div_-100/-7",   1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 1'b0);
    check_op("div_min/1",     1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0);
    check_op("div_-7/2",      1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
    check_op("div_max/min",   1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         1'b0);
    check_op("div_7/100",     1'b1, 32'd7,         32'd100,       32'd0,         1'b0);
    repeat (10) @(posedge clock);
    #1;
    n_vec++;
    if (data_result !== 32'd0 || data_exception !== 1'b0) begin
      n_bad++; $display("FAIL div_hold: got %h/%b want 00000000/0", data_result, data_exception);
    end
  endtask

  task automatic test_restart;
    int lat;
    bit chg;
    int rdy_seen;
    rdy_seen = 0;
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    for (int i = 0; i < 14; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1) rdy_seen++;
    end
    start_op(1'b0, 1'b1, 32'd10, 32'd2);
    wait_rdy(60, lat, chg);
    n_vec++;
    if (rdy_seen != 0 || lat !== 33) begin
      n_bad++; $display("FAIL restart_latency: got rdy_early=%0d lat=%0d want 0/33", rdy_seen, lat);
    end
    n_vec++;
    if (data_result !== 32'd5 || data_exception !== 1'b0) begin
      n_bad++; $display("FAIL restart_result: got %h/%b want 00000005/0", data_result, data_exception);
    end
  endtask

  task automatic test_abort_at_done;
    int lat;
    bit chg;
    start_op(1'b1, 1'b0, 32'd2, 32'd3);
    repeat (32) @(posedge clock);
    start_op(1'b1, 1'b0, 32'd5, 32'd5);   // sampled at E33 of the first op
    n_vec++;
    if (data_resultRDY !== 1'b0 || data_result !== 32'd5) begin
      n_bad++; $display("FAIL abort_e33: got rdy=%b res=%h want 0/00000005", data_resultRDY, data_result);
    end
    wait_rdy(60, lat, chg);
    n_vec++;
    if (lat !== 33 || data_result !== 32'd25) begin
      n_bad++; $display("FAIL abort_e33_next: got lat=%0d res=%h want 33/00000019", lat, data_result);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    bit chg;
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    wait_rdy(60, lat, chg);
    n_vec++;
    if (lat !== 33 || data_result !== 32'd42) begin
      n_bad++; $display("FAIL b2b_first: got lat=%0d res=%h want 33/0000002a", lat, data_result);
    end
    start_op(1'b0, 1'b1, 32'd81, 32'd9);   // sampled at E34 while RDY is visible
    n_vec++;
    if (data_resultRDY !== 1'b0 || data_result !== 32'd42) begin
      n_bad++; $display("FAIL b2b_pulse: got rdy=%b res=%h want 0/0000002a", data_resultRDY, data_result);
    end
    wait_rdy(60, lat, chg);
    n_vec++;
    if (lat !== 33 || data_result !== 32'd9 || chg) begin
      n_bad++; $display("FAIL b2b_second: got lat=%0d res=%h chg=%b want 33/00000009/0", lat, data_result, chg);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit chg;
    start_op(1'b1, 1'b0, 32'd123, 32'd456);
    repeat (19) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_vec++;
    if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_outputs: got %h/%b/%b want 00000000/0/0",
                        data_result, data_exception, data_resultRDY);
    end
    @(negedge clock);
    reset = 1'b0;
    wait_rdy(45, lat, chg);
    n_vec++;
    if (lat != -1) begin
      n_bad++; $display("FAIL reset_mid_no_rdy: got rdy at %0d want none", lat);
    end
  endtask

  task automatic test_both_ctrl;
    int lat;
    bit chg;
    start_op(1'b1, 1'b1, 32'd9, 32'd9);
    wait_rdy(45, lat, chg);
    n_vec++;
    if (lat != -1 || data_result !== 32'd0) begin
      n_bad++; $display("FAIL both_ctrl: got lat=%0d res=%h want none/00000000", lat, data_result);
    end
  endtask

  function automatic logic [31:0] rand_word();
    int k;
    logic [31:0] v;
    k = $urandom_range(0, 3);
    v = $urandom;
    case (k)
      0: rand_word = v;
      1: rand_word = 32'($urandom_range(0, 15));
      2: rand_word = 32'd0 - 32'($urandom_range(0, 15));
      default: rand_word = v >>> $urandom_range(0, 31);
    endcase
  endfunction

  task automatic test_random;
    int          lat;
    bit          chg;
    bit          div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] er;
    logic        ee;
    longint      pa;
    longint      pb;
    longint      p;
    int          ia;
    int          ib;
    for (int n = 0; n < 500; n++) begin
      div = n[0];
      a   = rand_word();
      b   = rand_word();
      if (!div) begin
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        p  = pa * pb;
        er = p[31:0];
        ee = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      end else if (b == 32'd0) begin
        er = 32'd0;
        ee = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        er = 32'h8000_0000;
        ee = 1'b1;
      end else begin
        ia = $signed(a);
        ib = $signed(b);
        er = 32'(ia / ib);
        ee = 1'b0;
      end
      start_op(!div, div, a, b);
      wait_rdy(60, lat, chg);
      n_vec++;
      if (lat !== 33 || chg || data_result !== er || data_exception !== ee) begin
        n_bad++;
        $display("FAIL rand_%s a=%h b=%h: got lat=%0d chg=%b res=%h exc=%b want 33/0/%h/%b",
                 div ? "div" : "mul", a, b, lat, chg, data_result, data_exception, er, ee);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    test_reset();
    test_mul();
    test_div();
    test_restart();
    test_abort_at_done();
    test_back_to_back();
    test_reset_mid();
    test_both_ctrl();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
